// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a runtime-programmable pattern of 1..MAX_LEN bits,
// selectable overlap mode, registered match pulse and saturating match counter.
module seq_detect_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b00101010),
  parameter int                 DEF_LEN     = 6,
  parameter bit                 DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;
  logic               sample;
  logic               match;
  logic               cfg_legal;
  logic               count_sat;

  // NOTE: every always_comb output gets a default before any conditional logic,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    hist_n    = {hist[MAX_LEN-2:0], x};
    fill_n    = (fill == FILL_MAX) ? fill : fill + LEN_W'(1);
    mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    sample    = x_valid && !cfg_load;
    // Only the low len bits take part; older history bits are masked off.
    match     = sample && (fill_n >= len) && ((hist_n & mask) == (pattern & mask));
    cfg_legal = (cfg_len != '0) && (cfg_len <= FILL_MAX);
    count_sat = &match_count;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= DEF_PATTERN;
      len     <= LEN_W'(DEF_LEN);
      overlap <= DEF_OVERLAP;
      z       <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      z       <= match;
      cfg_err <= 1'b0;
      if (cfg_load) begin
        // A load always discards the concurrent sample, legal or not.
        if (cfg_legal) begin
          pattern <= cfg_pattern;
          len     <= cfg_len;
          overlap <= cfg_overlap;
          hist    <= '0;
          fill    <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (x_valid) begin
        hist <= hist_n;
        fill <= (match && !overlap) ? '0 : fill_n;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
    end else if (count_clr) begin
      match_count <= match ? CNT_W'(1) : '0;
    end else if (match && !count_sat) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: two instances (8-bit and 2-bit counters) share
// one stimulus stream; expected values are hand-computed per step.
module tb_seq_detect_param;

  logic       clk;
  logic       reset;
  logic       x;
  logic       x_valid;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       count_clr;

  logic       z;
  logic [7:0] match_count;
  logic       cfg_err;
  logic       z2;
  logic [1:0] match_count2;
  logic       cfg_err2;

  int n_vec = 0;
  int n_err = 0;

  seq_detect_param dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .z(z), .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .z(z2), .match_count(match_count2), .cfg_err(cfg_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic sample(input logic b);
    x       = b;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic idle();
    x_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic clr, input logic exp_err);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    count_clr   = clr;
    @(posedge clk);
    #1;
    cfg_load  = 1'b0;
    count_clr = 1'b0;
    check("load_err", cfg_err, exp_err);
    check("load_z", z, 1'b0);
  endtask

  initial begin
    logic [9:0]  bits10;
    logic [9:0]  zx10;
    logic [11:0] bits12;
    logic [11:0] zx12;
    logic [5:0]  bits6;
    logic [5:0]  zx6;
    logic [4:0]  bits5;
    logic [4:0]  zx5;
    logic [2:0]  bits3;
    logic [2:0]  zx3;

    reset       = 1'b0;
    x           = 1'b0;
    x_valid     = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    count_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_z", z, 1'b0);
    check("rst_count", match_count, 8'd0);
    check("rst_err", cfg_err, 1'b0);
    reset = 1'b1;

    // Default config (101010, overlap): matches after samples 6, 8, 10.
    bits10 = 10'b1010101010;
    zx10   = 10'b0000010101;
    for (int i = 9; i >= 0; i--) begin
      sample(bits10[i]);
      check("t1_z", z, zx10[i]);
    end
    check("t1_count", match_count, 8'd3);

    // Non-overlap 101010: matches after samples 6 and 12 only.
    load(8'b00101010, 4'd6, 1'b0, 1'b1, 1'b0);
    check("t2_clr", match_count, 8'd0);
    bits12 = 12'b101010101010;
    zx12   = 12'b000001000001;
    for (int i = 11; i >= 0; i--) begin
      sample(bits12[i]);
      check("t2_z", z, zx12[i]);
    end
    check("t2_count", match_count, 8'd2);

    // Overlap 101010 with idle gaps of 1..3 cycles between valid bits.
    load(8'b00101010, 4'd6, 1'b1, 1'b1, 1'b0);
    bits6 = 6'b101010;
    for (int k = 1; k <= 6; k++) begin
      sample(bits6[6-k]);
      check("t3_z", z, (k == 6));
      for (int g = 0; g < (k % 3) + 1; g++) begin
        idle();
        check("t3_gap_z", z, 1'b0);
      end
    end
    check("t3_count", match_count, 8'd1);

    // Pattern 110, overlap.
    load(8'b00000110, 4'd3, 1'b1, 1'b1, 1'b0);
    bits6 = 6'b110110;
    zx6   = 6'b001001;
    for (int i = 5; i >= 0; i--) begin
      sample(bits6[i]);
      check("t4_z", z, zx6[i]);
    end
    check("t4_count", match_count, 8'd2);

    // Illegal length 0 with a concurrent sample: config, history and sample all ignored.
    x       = 1'b1;
    x_valid = 1'b1;
    load(8'hFF, 4'd0, 1'b0, 1'b0, 1'b1);
    x_valid = 1'b0;
    idle();
    check("t4_err_clear", cfg_err, 1'b0);
    bits5 = 5'b10110;
    zx5   = 5'b00001;
    for (int i = 4; i >= 0; i--) begin
      sample(bits5[i]);
      check("t4_keep_z", z, zx5[i]);
    end
    check("t4_keep_count", match_count, 8'd3);

    // Illegal length above MAX_LEN.
    load(8'h01, 4'd9, 1'b0, 1'b0, 1'b1);
    idle();
    check("t4_err9_clear", cfg_err, 1'b0);
    bits3 = 3'b110;
    zx3   = 3'b001;
    for (int i = 2; i >= 0; i--) begin
      sample(bits3[i]);
      check("t4_keep9_z", z, zx3[i]);
    end
    check("t4_keep9_count", match_count, 8'd4);

    // len=1, pattern 1, overlap: 2-bit counter saturates at 3.
    load(8'b00000001, 4'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sample(1'b1);
      check("t5_z", z, 1'b1);
      check("t5_count8", match_count, 8'(i + 1));
      check("t5_count2", match_count2, (i < 3) ? (i + 1) : 3);
    end
    count_clr = 1'b1;
    sample(1'b1);
    count_clr = 1'b0;
    check("t5_clr_match8", match_count, 8'd1);
    check("t5_clr_match2", match_count2, 2'd1);

    // len=1 non-overlap still matches every sample; the load leaves the count alone.
    load(8'b00000001, 4'd1, 1'b0, 1'b0, 1'b0);
    bits3 = 3'b110;
    zx3   = 3'b110;
    for (int i = 2; i >= 0; i--) begin
      sample(bits3[i]);
      check("t5_nov_z", z, zx3[i]);
    end
    check("t5_nov_count8", match_count, 8'd3);
    check("t5_nov_count2", match_count2, 2'd3);

    // Partial 10101, reset, then 0: no match may straddle the reset.
    load(8'b00101010, 4'd6, 1'b1, 1'b0, 1'b0);
    bits5 = 5'b10101;
    for (int i = 4; i >= 0; i--) begin
      sample(bits5[i]);
      check("t6_pre_z", z, 1'b0);
    end
    reset = 1'b0;
    #1;
    check("t6_rst_count", match_count, 8'd0);
    check("t6_rst_z", z, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    sample(1'b0);
    check("t6_post_z", z, 1'b0);
    bits6 = 6'b101010;
    zx6   = 6'b000001;
    for (int i = 5; i >= 0; i--) begin
      sample(bits6[i]);
      check("t6_fresh_z", z, zx6[i]);
    end
    check("t6_count", match_count, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
